// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch-stage PC sequencer with imem req/ack handshake, stall hold and redirect drain.
// Optional FETCH_PERF_CNT_EN adds saturating redirect/stall counters.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  output logic        pc_sel_o,
  output logic [31:0] pc_o,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic        flush_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] redirect_cnt_o,
  output logic [15:0] stall_cnt_o
`endif
);
  typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_t;
  state_t state, state_d;
  logic [31:0] tgt, tgt_d, pc_d, if_pc_d, aligned;
  logic req_d, valid_d, drain_next;
  assign aligned     = redirect_pc_i & ~32'd3;
  assign pc_sel_o    = redirect_i;
  assign flush_o     = redirect_i;
  assign imem_addr_o = pc_o;
  // a redirect only needs draining if a request is outstanding and its ack has not arrived
  assign drain_next  = state == DRAIN ? !imem_ack_i : (state == REQ && imem_req_o && !imem_ack_i);
  always_comb begin
    state_d = state;
    pc_d    = pc_o;
    tgt_d   = tgt;
    req_d   = imem_req_o;
    valid_d = if_valid_o;
    if_pc_d = if_pc_o;
    if (redirect_i) begin
      valid_d = 1'b0;
      req_d   = 1'b1;
      state_d = drain_next ? DRAIN : REQ;
      tgt_d   = drain_next ? aligned : tgt;
      pc_d    = drain_next ? pc_o : aligned;
    end else begin
      case (state)
        REQ: begin
          if (imem_req_o && imem_ack_i) begin
            valid_d = 1'b1;
            if_pc_d = pc_o;
            pc_d    = pc_o + PC_INC;
            state_d = stall_i ? HOLD : REQ;
            req_d   = !stall_i;
          end else begin
            valid_d = if_valid_o & stall_i;
            req_d   = 1'b1;
          end
        end
        HOLD: begin
          state_d = stall_i ? HOLD : REQ;
          req_d   = !stall_i;
        end
        DRAIN: begin
          state_d = imem_ack_i ? REQ : DRAIN;
          pc_d    = imem_ack_i ? tgt : pc_o;
        end
        default: state_d = REQ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= REQ;
      pc_o       <= RESET_PC;
      tgt        <= '0;
      imem_req_o <= 1'b0;
      if_valid_o <= 1'b0;
      if_pc_o    <= '0;
    end else begin
      state      <= state_d;
      pc_o       <= pc_d;
      tgt        <= tgt_d;
      imem_req_o <= req_d;
      if_valid_o <= valid_d;
      if_pc_o    <= if_pc_d;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      if (redirect_i && redirect_cnt_o != 16'hFFFF) redirect_cnt_o <= redirect_cnt_o + 16'd1;
      if (state == HOLD && stall_i && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed scoreboard bench for fetch_pc_ctrl (default and wrap-around RESET_PC instances).
module tb_fetch_pc_ctrl;
  logic clk = 0, reset, stall_i, redirect_i, imem_ack_i;
  logic [31:0] redirect_pc_i;
  logic imem_req_o, pc_sel_o, if_valid_o, flush_o;
  logic [31:0] imem_addr_o, pc_o, if_pc_o;
  logic req2, sel2, valid2, flush2;
  logic [31:0] addr2, pc2, if_pc2;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] rcnt, scnt, rcnt2, scnt2;
`endif
  int n = 0, errs = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  fetch_pc_ctrl dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i), .pc_sel_o(pc_sel_o),
    .pc_o(pc_o), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .flush_o(flush_o)
`ifdef FETCH_PERF_CNT_EN
    , .redirect_cnt_o(rcnt), .stall_cnt_o(scnt)
`endif
  );
  fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_ack_i(imem_ack_i), .pc_sel_o(sel2),
    .pc_o(pc2), .if_valid_o(valid2), .if_pc_o(if_pc2), .flush_o(flush2)
`ifdef FETCH_PERF_CNT_EN
    , .redirect_cnt_o(rcnt2), .stall_cnt_o(scnt2)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic cyc(input logic r, input logic st, input logic rd, input logic [31:0] rpc, input logic ak);
    logic [31:0] e;
    @(negedge clk);
    reset = r; stall_i = st; redirect_i = rd; redirect_pc_i = rpc; imem_ack_i = ak;
    #1;
    chk("pc_sel", pc_sel_o, rd);
    chk("flush", flush_o, rd);
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("if_pc", if_pc_o, e);
      chk("if_valid", if_valid_o, 1);
    end
  endtask
  initial begin
    reset = 1; stall_i = 0; redirect_i = 0; redirect_pc_i = 0; imem_ack_i = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_req", imem_req_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_valid", if_valid_o, 0);
    chk("rst_ifpc", if_pc_o, 0);
    chk("rst_pc2", pc2, 32'hFFFF_FFF8);
    cyc(0, 0, 0, 0, 1);
    chk("first_req", imem_req_o, 1);
    chk("addr0", imem_addr_o, 0);
    chk("valid_pre", if_valid_o, 0);
    chk("addr2_0", addr2, 32'hFFFF_FFF8);
    exp_q.push_back(32'h0);
    cyc(0, 0, 0, 0, 1);
    chk("addr4", imem_addr_o, 32'h4);
    chk("addr2_1", addr2, 32'hFFFF_FFFC);
    exp_q.push_back(32'h4);
    cyc(0, 0, 0, 0, 1);
    chk("addr8", imem_addr_o, 32'h8);
    chk("addr2_wrap", addr2, 32'h0);
    exp_q.push_back(32'h8);
    cyc(0, 1, 0, 0, 1);
    chk("hold_req", imem_req_o, 0);
    chk("hold_pc", pc_o, 32'hC);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("hold_req2", imem_req_o, 0);
    chk("hold_ifpc", if_pc_o, 32'h8);
    chk("hold_valid", if_valid_o, 1);
    chk("hold_pc2", pc_o, 32'hC);
    cyc(0, 0, 0, 0, 0);
    chk("resume_req", imem_req_o, 1);
    chk("resume_addr", imem_addr_o, 32'hC);
    chk("resume_valid", if_valid_o, 1);
    cyc(0, 0, 0, 0, 0);
    chk("handoff_valid", if_valid_o, 0);
    chk("handoff_addr", imem_addr_o, 32'hC);
    exp_q.push_back(32'hC);
    cyc(0, 0, 0, 0, 1);
    chk("addr10", imem_addr_o, 32'h10);
    cyc(0, 0, 1, 32'h40, 0);
    chk("drain_addr", imem_addr_o, 32'h10);
    chk("drain_req", imem_req_o, 1);
    chk("drain_valid", if_valid_o, 0);
    cyc(0, 0, 0, 0, 1);
    chk("drop_valid", if_valid_o, 0);
    chk("addr40", imem_addr_o, 32'h40);
    exp_q.push_back(32'h40);
    cyc(0, 0, 0, 0, 1);
    chk("addr44", imem_addr_o, 32'h44);
    cyc(0, 0, 1, 32'h103, 1);
    chk("ackredir_addr", imem_addr_o, 32'h100);
    chk("ackredir_valid", if_valid_o, 0);
    exp_q.push_back(32'h100);
    cyc(0, 1, 0, 0, 1);
    chk("hold2_req", imem_req_o, 0);
    chk("hold2_pc", pc_o, 32'h104);
    cyc(0, 1, 1, 32'h200, 0);
    chk("holdredir_addr", imem_addr_o, 32'h200);
    chk("holdredir_req", imem_req_o, 1);
    chk("holdredir_valid", if_valid_o, 0);
    cyc(0, 0, 1, 32'h300, 0);
    chk("drain2_addr", imem_addr_o, 32'h200);
    cyc(0, 1, 1, 32'h404, 0);
    chk("drain3_addr", imem_addr_o, 32'h200);
    cyc(0, 0, 0, 0, 1);
    chk("retarget_addr", imem_addr_o, 32'h404);
    chk("retarget_valid", if_valid_o, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("redirect_cnt", rcnt, 5);
    chk("stall_cnt", scnt, 3);
`endif
    cyc(0, 0, 1, 32'h500, 0);
    chk("drain4_addr", imem_addr_o, 32'h404);
    cyc(1, 0, 0, 0, 0);
    chk("rst2_req", imem_req_o, 0);
    chk("rst2_pc", pc_o, 0);
    chk("rst2_valid", if_valid_o, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("redirect_cnt_rst", rcnt, 0);
    chk("stall_cnt_rst", scnt, 0);
`endif
    cyc(0, 0, 0, 0, 1);
    chk("post_rst_req", imem_req_o, 1);
    chk("post_rst_addr", imem_addr_o, 0);
    exp_q.push_back(32'h0);
    cyc(0, 0, 0, 0, 1);
    chk("post_rst_next", imem_addr_o, 32'h4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n, errs);
    $finish;
  end
endmodule
